// File: rtl/fsm_envase.sv
// fsm_envase: bottling-line sequencer.
// Runs the conveyor until a bottle arrives, then fills, caps and releases it.
// It counts finished bottles (saturating) and latches an alarm when the
// conveyor or the fill step takes too long.
module fsm_envase #(
  parameter int MOVE_TIMEOUT = 100,
  parameter int FILL_TIMEOUT = 50,
  parameter int CAP_CYCLES   = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Sensor_Ativado,
  input  logic             Sensor_Nivel,
  output logic             Comando_Mover_Esteira,
  output logic             Valvula,
  output logic             Vedador,
  output logic             Alarme,
  output logic [CNT_W-1:0] Contador_Garrafas,
  output logic [2:0]       Estado
);

  // The timer must be wide enough to reach the largest limit minus one.
  localparam int MAX_AB  = (MOVE_TIMEOUT > FILL_TIMEOUT) ? MOVE_TIMEOUT : FILL_TIMEOUT;
  localparam int MAX_LIM = (MAX_AB > CAP_CYCLES) ? MAX_AB : CAP_CYCLES;
  localparam int TMR_W   = $clog2(MAX_LIM + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVENDO   = 3'd1,
    ST_ENCHENDO  = 3'd2,
    ST_VEDANDO   = 3'd3,
    ST_LIBERANDO = 3'd4,
    ST_ALARME    = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [TMR_W-1:0]   timer_r;
  logic               stop_req_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               move_exp_s;
  logic               fill_exp_s;
  logic               cap_exp_s;
  logic               mover_r;
  logic               valvula_r;
  logic               vedador_r;
  logic               alarme_r;

  // Expire flags: a timed state lasts exactly LIMIT cycles.
  assign move_exp_s = (timer_r == TMR_W'(MOVE_TIMEOUT - 1));
  assign fill_exp_s = (timer_r == TMR_W'(FILL_TIMEOUT - 1));
  assign cap_exp_s  = (timer_r == TMR_W'(CAP_CYCLES - 1));

  // Next-state selection, priorities in the order each state lists them.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start && !Stop) begin
          state_next_s = ST_MOVENDO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MOVENDO: begin
        if (stop_req_r || Stop) begin
          state_next_s = ST_IDLE;
        end else if (Sensor_Ativado) begin
          state_next_s = ST_ENCHENDO;
        end else if (move_exp_s) begin
          state_next_s = ST_ALARME;
        end else begin
          state_next_s = ST_MOVENDO;
        end
      end
      ST_ENCHENDO: begin
        // Stop is only remembered here; a started fill always completes.
        if (Sensor_Nivel) begin
          state_next_s = ST_VEDANDO;
        end else if (fill_exp_s) begin
          state_next_s = ST_ALARME;
        end else begin
          state_next_s = ST_ENCHENDO;
        end
      end
      ST_VEDANDO: begin
        if (cap_exp_s) begin
          state_next_s = ST_LIBERANDO;
        end else begin
          state_next_s = ST_VEDANDO;
        end
      end
      ST_LIBERANDO: begin
        if (!Sensor_Ativado) begin
          if (stop_req_r) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_MOVENDO;
          end
        end else if (move_exp_s) begin
          state_next_s = ST_ALARME;
        end else begin
          state_next_s = ST_LIBERANDO;
        end
      end
      ST_ALARME: begin
        state_next_s = ST_ALARME;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Dwell timer: restarts on every state change, counts while the state holds.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (state_next_s != state_r) begin
      timer_r <= {TMR_W{1'b0}};
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Latched stop request; dropped whenever the line goes to (or sits in) IDLE.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stop_req_r <= 1'b0;
    end else if (state_next_s == ST_IDLE) begin
      stop_req_r <= 1'b0;
    end else if (Stop) begin
      stop_req_r <= 1'b1;
    end else begin
      stop_req_r <= stop_req_r;
    end
  end

  // Finished-bottle counter, bumped when capping ends, saturating at all ones.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_VEDANDO) && cap_exp_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Actuator registers load the decode of the state being entered, so they
  // change on the same edge as the state register and clear with it on Reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mover_r   <= 1'b0;
      valvula_r <= 1'b0;
      vedador_r <= 1'b0;
      alarme_r  <= 1'b0;
    end else begin
      mover_r   <= (state_next_s == ST_MOVENDO) || (state_next_s == ST_LIBERANDO);
      valvula_r <= (state_next_s == ST_ENCHENDO);
      vedador_r <= (state_next_s == ST_VEDANDO);
      alarme_r  <= (state_next_s == ST_ALARME);
    end
  end

  assign Comando_Mover_Esteira = mover_r;
  assign Valvula               = valvula_r;
  assign Vedador               = vedador_r;
  assign Alarme                = alarme_r;
  assign Contador_Garrafas     = cnt_r;
  assign Estado                = state_r;

endmodule

// File: tb/tb_fsm_envase.sv
// Directed bench for fsm_envase: one default instance plus a CNT_W=2 copy
// sharing the same stimulus, to observe counter saturation.
module tb_fsm_envase;

  logic       clk;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Sensor_Ativado;
  logic       Sensor_Nivel;
  logic       mover;
  logic       valv;
  logic       ved;
  logic       alm;
  logic [7:0] cnt;
  logic [2:0] est;
  logic       mover2;
  logic       valv2;
  logic       ved2;
  logic       alm2;
  logic [1:0] cnt2;
  logic [2:0] est2;

  int total;
  int bad;

  fsm_envase #(.MOVE_TIMEOUT(100), .FILL_TIMEOUT(50), .CAP_CYCLES(8), .CNT_W(8)) u_dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Sensor_Ativado(Sensor_Ativado), .Sensor_Nivel(Sensor_Nivel),
    .Comando_Mover_Esteira(mover), .Valvula(valv), .Vedador(ved),
    .Alarme(alm), .Contador_Garrafas(cnt), .Estado(est)
  );

  fsm_envase #(.MOVE_TIMEOUT(100), .FILL_TIMEOUT(50), .CAP_CYCLES(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Sensor_Ativado(Sensor_Ativado), .Sensor_Nivel(Sensor_Nivel),
    .Comando_Mover_Esteira(mover2), .Valvula(valv2), .Vedador(ved2),
    .Alarme(alm2), .Contador_Garrafas(cnt2), .Estado(est2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    Reset = 1'b1;
    #1;
    check("rst_est", 32'(est), 32'd0);
    check("rst_alm", 32'(alm), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    Reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    Reset = 1'b1;
    Start = 1'b0;
    Stop = 1'b0;
    Sensor_Ativado = 1'b0;
    Sensor_Nivel = 1'b0;
    #12;
    check("reset_est",   32'(est),   32'd0);
    check("reset_mover", 32'(mover), 32'd0);
    check("reset_valv",  32'(valv),  32'd0);
    check("reset_ved",   32'(ved),   32'd0);
    check("reset_alm",   32'(alm),   32'd0);
    check("reset_cnt",   32'(cnt),   32'd0);
    Reset = 1'b0;

    // ---- Scenario 1: full bottle cycle, Stop during release ----
    Start = 1'b1;
    tick();
    check("s1_mov_est", 32'(est), 32'd1);
    check("s1_mov_cmd", 32'(mover), 32'd1);
    tick(); tick(); tick();
    check("s1_mov_hold", 32'(est), 32'd1);
    Sensor_Ativado = 1'b1;  // cycle 5 of MOVENDO
    tick();
    check("s1_fill_est", 32'(est), 32'd2);
    check("s1_fill_cmd", 32'(mover), 32'd0);
    for (int i = 0; i < 9; i++) begin
      check("s1_valv_on", 32'(valv), 32'd1);
      tick();
    end
    check("s1_valv_10", 32'(valv), 32'd1);
    Sensor_Nivel = 1'b1;
    tick();
    Sensor_Nivel = 1'b0;
    check("s1_cap_est", 32'(est), 32'd3);
    check("s1_valv_off", 32'(valv), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("s1_ved_on", 32'(ved), 32'd1);
      check("s1_cnt_pre", 32'(cnt), 32'd0);
      tick();
    end
    check("s1_lib_est", 32'(est), 32'd4);
    check("s1_ved_off", 32'(ved), 32'd0);
    check("s1_lib_cmd", 32'(mover), 32'd1);
    check("s1_cnt", 32'(cnt), 32'd1);
    Stop = 1'b1;
    tick(); tick();
    Sensor_Ativado = 1'b0;  // drops in cycle 3 of LIBERANDO
    tick();
    check("s1_idle_est", 32'(est), 32'd0);
    check("s1_idle_cmd", 32'(mover), 32'd0);
    tick();
    check("s1_idle_stay", 32'(est), 32'd0);
    Start = 1'b0;
    Stop = 1'b0;

    // ---- Boundary: Sensor_Ativado and Stop in the same MOVENDO cycle ----
    Start = 1'b1;
    tick();
    check("b_mov", 32'(est), 32'd1);
    Start = 1'b0;
    Sensor_Ativado = 1'b1;
    Stop = 1'b1;
    tick();
    check("b_stop_wins", 32'(est), 32'd0);
    Sensor_Ativado = 1'b0;
    Stop = 1'b0;

    // ---- Scenario 2: conveyor timeout ----
    Start = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      check("s2_cmd_on", 32'(mover), 32'd1);
      tick();
    end
    check("s2_alarm_est", 32'(est), 32'd5);
    check("s2_alarm", 32'(alm), 32'd1);
    check("s2_cmd_off", 32'(mover), 32'd0);
    for (int i = 0; i < 4; i++) begin
      Start = ~Start;
      tick();
      check("s2_sticky", 32'(alm), 32'd1);
    end
    check("s2_cnt_held", 32'(cnt), 32'd1);
    Start = 1'b0;
    pulse_reset();
    tick();
    check("s2_cleared", 32'(alm), 32'd0);

    // ---- Scenario 3a: fill timeout ----
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Sensor_Ativado = 1'b1;
    tick();
    check("s3_fill", 32'(est), 32'd2);
    for (int i = 0; i < 50; i++) begin
      check("s3_valv_on", 32'(valv), 32'd1);
      tick();
    end
    check("s3_alarm_est", 32'(est), 32'd5);
    check("s3_valv_off", 32'(valv), 32'd0);
    check("s3_alarm", 32'(alm), 32'd1);
    Sensor_Ativado = 1'b0;
    pulse_reset();

    // ---- Scenario 3b: Sensor_Nivel in the 50th cycle wins over expire ----
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Sensor_Ativado = 1'b1;
    tick();
    for (int i = 0; i < 49; i++) tick();
    check("s3b_still_fill", 32'(est), 32'd2);
    Sensor_Nivel = 1'b1;
    tick();
    Sensor_Nivel = 1'b0;
    check("s3b_cap", 32'(est), 32'd3);
    check("s3b_no_alarm", 32'(alm), 32'd0);
    Sensor_Ativado = 1'b0;
    pulse_reset();

    // ---- Scenario 4: Stop pulse during fill finishes the bottle then idles ----
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Sensor_Ativado = 1'b1;
    tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("s4_fill_kept", 32'(est), 32'd2);
    Sensor_Nivel = 1'b1;
    tick();
    Sensor_Nivel = 1'b0;
    check("s4_cap", 32'(est), 32'd3);
    for (int i = 0; i < 8; i++) tick();
    check("s4_lib", 32'(est), 32'd4);
    check("s4_cnt", 32'(cnt), 32'd1);
    Sensor_Ativado = 1'b0;
    tick();
    check("s4_idle", 32'(est), 32'd0);
    Start = 1'b1;
    tick();
    check("s4_restart", 32'(est), 32'd1);
    tick();
    check("s4_stopreq_clr", 32'(est), 32'd1);
    Start = 1'b0;
    pulse_reset();

    // ---- Scenario 5: back-to-back bottles, counter saturation at CNT_W=2 ----
    Start = 1'b1;
    tick();
    for (int b = 0; b < 5; b++) begin
      check("s5_mov", 32'(est), 32'd1);
      Sensor_Ativado = 1'b1;
      Sensor_Nivel = 1'b1;  // already full on entry: one fill cycle
      tick();
      check("s5_fill", 32'(est), 32'd2);
      tick();
      check("s5_cap", 32'(est), 32'd3);
      Sensor_Nivel = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("s5_lib", 32'(est), 32'd4);
      check("s5_cnt8", 32'(cnt), 32'(b + 1));
      check("s5_cnt2", 32'(cnt2), (b < 3) ? 32'(b + 1) : 32'd3);
      Sensor_Ativado = 1'b0;
      tick();
    end
    check("s5_no_idle", 32'(est), 32'd1);

    // ---- Scenario 6: Reset mid-VEDANDO clears actuators immediately ----
    Sensor_Ativado = 1'b1;
    Sensor_Nivel = 1'b1;
    tick();
    tick();
    Sensor_Nivel = 1'b0;
    tick(); tick(); tick();
    check("s6_ved_on", 32'(ved), 32'd1);
    check("s6_cnt_pre", 32'(cnt), 32'd5);
    #2;
    Reset = 1'b1;
    #1;
    check("s6_ved_off", 32'(ved), 32'd0);
    check("s6_est", 32'(est), 32'd0);
    check("s6_cnt", 32'(cnt), 32'd0);
    check("s6_cnt2", 32'(cnt2), 32'd0);
    Start = 1'b0;
    Sensor_Ativado = 1'b0;
    Reset = 1'b0;
    tick();
    check("s6_idle", 32'(est), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_envase.md
Name: fsm_envase

Overview:
- Line sequencer for the wine-bottling conveyor. It issues Comando_Mover_Esteira to the conveyor motor FSM, which stops the motor itself on Sensor_Ativado or when the command drops.
- On each bottle arrival it sequences fill valve, then capper, then release.
- It counts finished bottles and raises an alarm on conveyor or fill timeouts.
- It sits above the motor FSM in the line top level and shares its clk, Reset and Sensor_Ativado.

Parameters:
- MOVE_TIMEOUT, 100: max cycles in MOVENDO or LIBERANDO before alarm (>=2).
- FILL_TIMEOUT, 50: max cycles in ENCHENDO without Sensor_Nivel before alarm (>=2).
- CAP_CYCLES, 8: exact cycles Vedador is held high (>=1).
- CNT_W, 8: width of the bottle counter.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; begin or continue the line from IDLE.
- Stop  in  1  level; request stop, latched (see Behaviour).
- Sensor_Ativado  in  1  bottle present at fill position.
- Sensor_Nivel  in  1  bottle full.
- Comando_Mover_Esteira  out  1  conveyor run command to the motor FSM.
- Valvula  out  1  fill valve open.
- Vedador  out  1  capper actuate.
- Alarme  out  1  timeout fault.
- Contador_Garrafas  out  CNT_W  finished bottles, saturating.
- Estado  out  3  current state code.

Behaviour:

Reset and outputs
- Reset (async, active-high) clears the following: state=IDLE, timer=0, stop_req=0, Contador_Garrafas=0. All outputs are 0.
- Moore outputs, decoded only from the state register. A transition at edge k changes the outputs right after edge k.
- State codes: IDLE=0, MOVENDO=1, ENCHENDO=2, VEDANDO=3, LIBERANDO=4, ALARME=5. Codes 6 and 7 go to IDLE on the next edge.
- Output decode:
  - MOVENDO and LIBERANDO: Comando_Mover_Esteira=1.
  - ENCHENDO: Valvula=1.
  - VEDANDO: Vedador=1.
  - ALARME: Alarme=1.
  - All other outputs are 0 in every state.

Timer
- One timer register, cleared on every state change. It increments every cycle the state is unchanged.
- "Expire" means timer==LIMIT-1, so a timed state occupies exactly LIMIT cycles.

stop_req
- Set on any cycle with Stop=1. Cleared when entering IDLE.

Transitions (evaluated at each rising edge, priority in listed order)
- IDLE:
  - Start=1 and Stop=0 → MOVENDO.
  - Otherwise stay.
- MOVENDO:
  - stop_req or Stop → IDLE.
  - Sensor_Ativado → ENCHENDO.
  - Expire(MOVE_TIMEOUT) → ALARME.
- ENCHENDO (Stop does not abort):
  - Sensor_Nivel → VEDANDO.
  - Expire(FILL_TIMEOUT) → ALARME.
- VEDANDO:
  - Expire(CAP_CYCLES) → LIBERANDO. On that same edge Contador_Garrafas += 1, saturating at 2^CNT_W-1.
- LIBERANDO:
  - Sensor_Ativado=0 → IDLE if stop_req, else MOVENDO.
  - Expire(MOVE_TIMEOUT) → ALARME.
- ALARME: sticky; only Reset exits it. Counter is held.

Boundary rules
- Sensor_Nivel already high on entry to ENCHENDO → VEDANDO after exactly 1 ENCHENDO cycle.
- Sensor_Nivel and expire in the same cycle → VEDANDO (sensor wins).
- Sensor_Ativado and Stop in the same MOVENDO cycle → IDLE.
- Start held continuously gives back-to-back bottles with no IDLE cycle.
- Reset mid-state forces IDLE immediately with all actuators off, including the Valvula mid-fill.

Test Plan:
- Reset, Start=1; Sensor_Ativado at cycle 5 (MOVENDO). Sensor_Nivel 10 cycles after ENCHENDO entry. Sensor_Ativado drops 3 cycles into LIBERANDO, Stop=1 meanwhile.
  - Required: Estado 0→1→2→3→4→0; Valvula high 10 cycles; Vedador high exactly 8 cycles; Contador_Garrafas=1; IDLE after LIBERANDO.
- Start=1, Sensor_Ativado never asserted → Comando high exactly 100 cycles, then Alarme=1 and Comando=0. Alarme stays set with Start toggling; Reset clears it.
- In ENCHENDO, Sensor_Nivel=0 for 50 cycles → ALARME at the 50th edge, Valvula=0. A second run with Sensor_Nivel rising in cycle 50 → VEDANDO.
- Stop pulsed 1 cycle during ENCHENDO → fill, cap and release complete; count increments; then IDLE (not MOVENDO). stop_req is cleared, and Start then restarts the line.
- CNT_W=2, run 5 bottles continuously → counter reads 1,2,3,3,3.
- Assert Reset mid-VEDANDO → Vedador=0, Estado=0 and counter=0 immediately, before the next clk edge.
